// File: rtl/data_mem_port_pkg.sv
// Shared load/store definitions used by execute, decode and the data-memory port.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_t;

  // Unsupported funct3 encodings are treated as misaligned so they never touch the RAM.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = a[0];
      F3_W:        bad = (a != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Load/store request/response bundle between the execute stage and the data memory.
interface data_mem_port_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            busy;
  logic            ack;
  logic            misaligned;
  logic [XLEN-1:0] mem_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  busy, ack, misaligned, mem_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output busy, ack, misaligned, mem_data
  );
endinterface

// File: rtl/data_mem_port_dmem_ram.sv
// Single-port word RAM with per-byte write enables and one-cycle registered read.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_port.sv
// Data-memory responder: alignment check, byte-lane write steering and MSB-justified loads.
module data_mem_port
  import mem_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int DEPTH_WORDS = 1024,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic clk,
  input  logic reset,
  data_mem_port_if.slave bus
);
  mem_state_t      state, state_nx;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [2:0]      f3_q;
  logic            store_q, bad_q;
  logic            ack_q, mis_q;
  logic [XLEN-1:0] mem_data_q;

  logic [3:0]      be, ram_we;
  logic [31:0]     wlanes, rdata, load_just;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ack_q      <= 1'b0;
      mis_q      <= 1'b0;
      mem_data_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      store_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state <= state_nx;
      ack_q <= (state == ST_RESP);
      if (state == ST_IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
        store_q <= bus.req_store;
        bad_q   <= access_bad(bus.req_funct3, bus.req_addr[1:0]);
      end
      if (state == ST_RESP) begin
        mis_q      <= bad_q;
        mem_data_q <= (store_q || bad_q) ? '0 : XLEN'(load_just);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (access_bad(bus.req_funct3, bus.req_addr[1:0])) state_nx = ST_RESP;
          else if (bus.req_store)                            state_nx = ST_WRITE;
          else                                               state_nx = ST_READ;
        end
      end
      ST_READ:  state_nx = ST_RESP;
      ST_WRITE: state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Store source bytes are replicated across lanes so the byte enable alone picks the target.
  always_comb begin
    be     = 4'b1111;
    wlanes = wdata_q[31:0];
    case (f3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_just = rdata;
    case (f3_q[1:0])
      2'b00: load_just = {rdata[8*addr_q[1:0] +: 8], 24'h0};
      2'b01: load_just = {rdata[16*addr_q[1] +: 16], 16'h0};
      default: ;
    endcase
  end

  assign ram_we = (state == ST_WRITE && !reset) ? be : 4'b0000;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q[ADDR_W+1:2]),
    .wdata(wlanes),
    .rdata(rdata)
  );

  assign bus.busy       = (state != ST_IDLE);
  assign bus.ack        = ack_q;
  assign bus.misaligned = mis_q;
  assign bus.mem_data   = mem_data_q;
endmodule

// File: tb/tb_data_mem_port.sv
// Directed self-checking bench for data_mem_port.
module tb_data_mem_port;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_port_if #(.XLEN(32)) bus ();

  data_mem_port #(.XLEN(32), .DEPTH_WORDS(1024)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Drives one request from IDLE and returns latency (posedges from acceptance to ack) and results.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] data, output logic mis);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = bus.mem_data;
    mis  = bus.misaligned;
    if (!bus.ack) begin
      errors++;
      $display("FAIL ack_timeout addr=%h got no ack, required ack", a);
    end
    checks++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.ack); end
    checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", bus.misaligned); end
    checks++; if (bus.mem_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.mem_data); end
    reset = 1'b0;
  endtask

  task automatic test_word;
    int lat; logic [31:0] d; logic m;
    do_req(1'b1, F3_W, 32'h10, 32'hAABBCCDD, lat, d, m);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d want 3", lat); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_data got %h want 0", d); end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, d, m);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
    checks++; if (d !== 32'hAABBCCDD) begin errors++; $display("FAIL lw_data got %h want aabbccdd", d); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL lw_mis got %b want 0", m); end
  endtask

  task automatic test_subword;
    int lat; logic [31:0] d; logic m;
    do_req(1'b0, F3_B, 32'h11, 32'h0, lat, d, m);
    checks++; if (d !== 32'hCC000000) begin errors++; $display("FAIL lb_11 got %h want cc000000", d); end
    do_req(1'b0, F3_HU, 32'h12, 32'h0, lat, d, m);
    checks++; if (d !== 32'hAABB0000) begin errors++; $display("FAIL lhu_12 got %h want aabb0000", d); end
    do_req(1'b0, F3_H, 32'h10, 32'h0, lat, d, m);
    checks++; if (d !== 32'hCCDD0000) begin errors++; $display("FAIL lh_10 got %h want ccdd0000", d); end
    do_req(1'b0, F3_BU, 32'h13, 32'h0, lat, d, m);
    checks++; if (d !== 32'hAA000000) begin errors++; $display("FAIL lbu_13 got %h want aa000000", d); end
    do_req(1'b1, F3_B, 32'h13, 32'h00000011, lat, d, m);
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, d, m);
    checks++; if (d !== 32'h11BBCCDD) begin errors++; $display("FAIL sb_13 got %h want 11bbccdd", d); end
    do_req(1'b1, F3_H, 32'h20, 32'h00009988, lat, d, m);
    do_req(1'b0, F3_W, 32'h20, 32'h0, lat, d, m);
    checks++; if (d[15:0] !== 16'h9988) begin errors++; $display("FAIL sh_20 got %h want ....9988", d); end
    // address wraps modulo 4096 bytes
    do_req(1'b0, F3_W, 32'h1010, 32'h0, lat, d, m);
    checks++; if (d !== 32'h11BBCCDD) begin errors++; $display("FAIL wrap_1010 got %h want 11bbccdd", d); end
  endtask

  task automatic test_misaligned;
    int lat; logic [31:0] d; logic m;
    do_req(1'b1, F3_W, 32'h4, 32'h01020304, lat, d, m);
    do_req(1'b0, F3_W, 32'h6, 32'h0, lat, d, m);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_lw_latency got %0d want 2", lat); end
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_lw_flag got %b want 1", m); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mis_lw_data got %h want 0", d); end
    do_req(1'b1, F3_H, 32'h5, 32'hFFFFFFFF, lat, d, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_sh_flag got %b want 1", m); end
    do_req(1'b1, 3'b011, 32'h4, 32'hFFFFFFFF, lat, d, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL illegal_f3 got %b want 1", m); end
    do_req(1'b0, F3_W, 32'h4, 32'h0, lat, d, m);
    checks++; if (d !== 32'h01020304) begin errors++; $display("FAIL mis_nochange got %h want 01020304", d); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL aligned_mis got %b want 0", m); end
  endtask

  task automatic test_busy_ignore;
    int acks; int lat; logic [31:0] d; logic m;
    acks = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.req_store = 1'b1; bus.req_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) bus.req_valid = 1'b0;
      if (bus.ack) acks++;
      @(negedge clk);
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL busy_ack_count got %0d want 1", acks); end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, d, m);
    checks++; if (d !== 32'h11BBCCDD) begin errors++; $display("FAIL busy_nowrite got %h want 11bbccdd", d); end
  endtask

  task automatic test_reset_write;
    int lat; logic [31:0] d; logic m;
    do_req(1'b1, F3_W, 32'h20, 32'hCAFEF00D, lat, d, m);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_wr_busy got %b want 0", bus.busy); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rst_wr_ack got %b want 0", bus.ack); end
    @(negedge clk);
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rst_wr_late_ack got %b want 0", bus.ack); end
    do_req(1'b0, F3_W, 32'h20, 32'h0, lat, d, m);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_wr_data got %h want cafef00d", d); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_busy_ignore();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
